// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Microcode sequencer for the 8-bit computer. Steps through the fetch
//   (T0/T1) and execute (T2..T4) micro-steps of the opcode held in IR[7:4].
//   Each step it drives the control word for the PC, MAR, RAM, IR, A/B,
//   ALU, flags and output register. It is the only source of CE/J/CO.
//
// Parameters
//   NUM_STEPS  micro-steps per instruction (T0..T(NUM_STEPS-1))
//   EARLY_END  1: return to T0 after the last useful step; 0: always run all steps
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   rst      in   synchronous active-high reset
//   step_en  in   advance enable; 0 freezes the step counter
//   opcode   in   4-bit opcode (IR[7:4])
//   flag_c   in   registered carry flag
//   flag_z   in   registered zero flag
//   step     out  current micro-step (debug/LEDs)
//   halted   out  HLT executed; sticky until rst
//   ctrl     out  {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [2:0]  step,
    output logic        halted,
    output logic [15:0] ctrl
);

    localparam int            SW   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);
    localparam logic [SW-1:0] T2   = SW'(2);

    // Control word bit masks, msb..lsb.
    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Microcode ROM: control word for step s of opcode op. Opcodes 9..D
    // match no item and behave as NOP.
    function automatic logic [15:0] word_at(input logic [SW-1:0] s,
                                            input logic [3:0]    op,
                                            input logic          c,
                                            input logic          z);
        logic [15:0] w;
        w = '0;
        case (int'(s))
            0: w = C_CO | C_MI;
            1: w = C_RO | C_II | C_CE;
            2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w = C_IO | C_MI;
                    OP_LDI: w = C_IO | C_AI;
                    OP_JMP: w = C_IO | C_J;
                    OP_JC:  w = c ? (C_IO | C_J) : '0;
                    OP_JZ:  w = z ? (C_IO | C_J) : '0;
                    OP_OUT: w = C_AO | C_OI;
                    OP_HLT: w = C_HLT;
                    default: w = '0;
                endcase
            end
            3: begin
                case (op)
                    OP_LDA:         w = C_RO | C_AI;
                    OP_ADD, OP_SUB: w = C_RO | C_BI;
                    OP_STA:         w = C_AO | C_RI;
                    default:        w = '0;
                endcase
            end
            4: begin
                case (op)
                    OP_ADD:  w = C_EO | C_AI | C_FI;
                    OP_SUB:  w = C_EO | C_AI | C_SU | C_FI;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [SW-1:0] step_q, step_d;
    logic          halted_q, halted_d;
    logic [15:0]   next_word;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        step_d   = step_q;
        halted_d = halted_q;
        // Look-ahead forces the flags true: flags matter only while in T2,
        // so a conditional jump always occupies its T2 slot even when it
        // will not be taken (T2 then shows an all-zero word).
        next_word = word_at(step_q + 1'b1, opcode, 1'b1, 1'b1);

        if (step_en && !halted_q) begin
            if (step_q == T2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
            if (step_q == LAST || (EARLY_END && next_word == '0)) begin
                step_d = '0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign ctrl   = halted_q ? C_HLT : word_at(step_q, opcode, flag_c, flag_z);
    assign step   = 3'(step_q);
    assign halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. Runs an EARLY_END=1 and an
//   EARLY_END=0 instance side by side on the same stimulus; a reference
//   model built from per-opcode micro-op lists and instruction lengths
//   predicts step, halted and ctrl for both every cycle.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_en = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;

    logic [2:0]  step_e, step_f;
    logic        halted_e, halted_f;
    logic [15:0] ctrl_e, ctrl_f;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: index 0 = EARLY_END=1 build, 1 = EARLY_END=0 build.
    int m_step [2];
    bit m_halt [2];
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    control_unit #(.NUM_STEPS(5), .EARLY_END(1'b1)) u_dut (
        .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .step(step_e), .halted(halted_e), .ctrl(ctrl_e)
    );

    control_unit #(.NUM_STEPS(5), .EARLY_END(1'b0)) u_dut_full (
        .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .step(step_f), .halted(halted_f), .ctrl(ctrl_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Total steps an instruction occupies when it ends early.
    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4:                         return 4;
            4'h2, 4'h3:                         return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
            default:                            return 2;
        endcase
    endfunction

    // Execute-phase micro-op list, k = 0..2 for T2..T4.
    function automatic logic [15:0] exec_word(input logic [3:0] op, input int k,
                                              input logic c, input logic z);
        logic [15:0] w [3];
        w = '{16'h0, 16'h0, 16'h0};
        case (op)
            4'h1: w = '{IO | MI, RO | AI, 16'h0};
            4'h2: w = '{IO | MI, RO | BI, EO | AI | FI};
            4'h3: w = '{IO | MI, RO | BI, EO | AI | SU | FI};
            4'h4: w = '{IO | MI, AO | RI, 16'h0};
            4'h5: w = '{IO | AI, 16'h0, 16'h0};
            4'h6: w = '{IO | J, 16'h0, 16'h0};
            4'h7: w = '{c ? (IO | J) : 16'h0, 16'h0, 16'h0};
            4'h8: w = '{z ? (IO | J) : 16'h0, 16'h0, 16'h0};
            4'hE: w = '{AO | OI, 16'h0, 16'h0};
            4'hF: w = '{HLT, 16'h0, 16'h0};
            default: ;
        endcase
        return w[k];
    endfunction

    function automatic logic [15:0] exp_ctrl(input int b);
        if (m_halt[b])        return HLT;
        if (m_step[b] == 0)   return CO | MI;
        if (m_step[b] == 1)   return RO | II | CE;
        return exec_word(opcode, m_step[b] - 2, flag_c, flag_z);
    endfunction

    task automatic model_edge();
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                m_step[b] = 0;
                m_halt[b] = 1'b0;
            end else if (step_en && !m_halt[b]) begin
                if (m_step[b] == 2 && opcode == 4'hF) m_halt[b] = 1'b1;
                if (m_step[b] + 1 >= ((b == 0) ? instr_len(opcode) : 5)) m_step[b] = 0;
                else m_step[b] = m_step[b] + 1;
            end
        end
    endtask

    task automatic compare();
        check("early_step",   32'(step_e),   32'(m_step[0]));
        check("early_halted", 32'(halted_e), 32'(m_halt[0]));
        check("early_ctrl",   32'(ctrl_e),   32'(exp_ctrl(0)));
        check("full_step",    32'(step_f),   32'(m_step[1]));
        check("full_halted",  32'(halted_f), 32'(m_halt[1]));
        check("full_ctrl",    32'(ctrl_f),   32'(exp_ctrl(1)));
        check("early_bus_onehot",
              32'($onehot0({ctrl_e[2], ctrl_e[12], ctrl_e[11], ctrl_e[8], ctrl_e[7]})), 32'(1));
        check("early_j_ce", 32'(ctrl_e[1] & ctrl_e[3]), 32'(0));
        check("full_bus_onehot",
              32'($onehot0({ctrl_f[2], ctrl_f[12], ctrl_f[11], ctrl_f[8], ctrl_f[7]})), 32'(1));
        check("full_j_ce", 32'(ctrl_f[1] & ctrl_f[3]), 32'(0));
    endtask

    // Apply inputs, then check everything just before the next rising edge.
    task automatic drive(input logic r, input logic en, input logic [3:0] op,
                         input logic c, input logic z);
        rst = r; step_en = en; opcode = op; flag_c = c; flag_z = z;
        @(negedge clk);
        if (model_valid) compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        model_valid = 1'b1;
        #1;
    endtask

    logic       r_i;
    logic [3:0] op_i;

    initial begin
        // Reset, then a full ADD instruction.
        drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        check("rst_step", 32'(step_e), 32'(0));
        check("rst_ctrl", 32'(ctrl_e), 32'(CO | MI));
        check("rst_halted", 32'(halted_e), 32'(0));
        adv();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        check("t1_step", 32'(step_e), 32'(1));
        check("t1_ctrl", 32'(ctrl_e), 32'(RO | II | CE));
        adv();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        check("add_t2", 32'(ctrl_e), 32'(IO | MI));
        adv();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        check("add_t3", 32'(ctrl_e), 32'(RO | BI));
        adv();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        check("add_t4_step", 32'(step_e), 32'(4));
        check("add_t4", 32'(ctrl_e), 32'(EO | AI | FI));
        adv();

        // JC taken, then JC not taken.
        for (int t = 1; t >= 0; t--) begin
            drive(1'b0, 1'b1, 4'h7, 1'(t), 1'b0);
            check("jc_t0_step", 32'(step_e), 32'(0));
            adv();
            drive(1'b0, 1'b1, 4'h7, 1'(t), 1'b0); adv();
            drive(1'b0, 1'b1, 4'h7, 1'(t), 1'b0);
            check("jc_t2_ctrl", 32'(ctrl_e), (t == 1) ? 32'(IO | J) : 32'(0));
            adv();
        end
        drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        check("jc_end_step", 32'(step_e), 32'(0));
        adv();

        // LDA frozen in T3 for three cycles.
        drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0); adv();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
            check("lda_hold_step", 32'(step_e), 32'(3));
            check("lda_hold_ctrl", 32'(ctrl_e), 32'(RO | AI));
            adv();
        end
        drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        check("lda_release_step", 32'(step_e), 32'(0));
        adv();

        // HLT: sticky halt, cleared only by rst.
        drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0); adv();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            check("hlt_halted", 32'(halted_e), 32'(1));
            check("hlt_ctrl", 32'(ctrl_e), 32'(HLT));
            adv();
        end
        drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("hlt_rst_step", 32'(step_e), 32'(0));
        check("hlt_rst_halted", 32'(halted_e), 32'(0));
        adv();

        // Random opcodes, flags, step_en and occasional reset.
        for (int i = 0; i < 10000; i++) begin
            if (m_halt[0] && m_halt[1]) r_i = ($urandom_range(3) == 0);
            else                        r_i = ($urandom_range(499) == 0);
            op_i = ($urandom_range(15) == 0) ? 4'hF : 4'($urandom_range(14));
            drive(r_i, ($urandom_range(3) != 0), op_i,
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
